// File: rtl/seq_ctrl_pkg.sv
// seq_ctrl_pkg: state, opcode, ALU and write-back encodings shared by the seq_controller slice.
package seq_ctrl_pkg;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StOpfetch,
        StMem,
        StHalt
    } state_e;

    typedef enum logic [3:0] {
        ClsNop,
        ClsAlu,
        ClsLdi,
        ClsLd,
        ClsSt,
        ClsJmp,
        ClsJz,
        ClsJnz,
        ClsHlt,
        ClsIll
    } instr_class_e;

    localparam int unsigned OpNop  = 0;
    localparam int unsigned OpAdd  = 1;
    localparam int unsigned OpSub  = 2;
    localparam int unsigned OpAnd  = 3;
    localparam int unsigned OpOr   = 4;
    localparam int unsigned OpXor  = 5;
    localparam int unsigned OpNot  = 6;
    localparam int unsigned OpMov  = 7;
    localparam int unsigned OpLdi  = 8;
    localparam int unsigned OpLd   = 9;
    localparam int unsigned OpSt   = 10;
    localparam int unsigned OpJmp  = 11;
    localparam int unsigned OpJz   = 12;
    localparam int unsigned OpJnz  = 13;
    localparam int unsigned OpRsvd = 14;
    localparam int unsigned OpHlt  = 15;

    localparam logic [2:0] AluAdd = 3'd0;
    localparam logic [2:0] AluSub = 3'd1;
    localparam logic [2:0] AluAnd = 3'd2;
    localparam logic [2:0] AluOr  = 3'd3;
    localparam logic [2:0] AluXor = 3'd4;
    localparam logic [2:0] AluNot = 3'd5;
    localparam logic [2:0] AluMov = 3'd6;

    localparam logic [1:0] WbAlu = 2'd0;
    localparam logic [1:0] WbImm = 2'd1;
    localparam logic [1:0] WbMem = 2'd2;

    function automatic logic [1:0] wb_sel_for(instr_class_e cls);
        case (cls)
            ClsLdi:  return WbImm;
            ClsLd:   return WbMem;
            default: return WbAlu;
        endcase
    endfunction

endpackage

// File: rtl/seq_ctrl_decode.sv
// seq_ctrl_decode: combinational instruction-word decoder (ALU op, register selects, class).
module seq_ctrl_decode
    import seq_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OPC_W  = 4,
    parameter int unsigned RSEL_W = 2
) (
    input  logic [DATA_W-1:0] ir,
    output logic [2:0]        alu_sel,
    output logic [RSEL_W-1:0] src_sel,
    output logic [RSEL_W-1:0] dst_sel,
    output logic [3:0]        instr_class
);

    logic [31:0] opc_val;
    logic        unused_ir;

    assign opc_val   = 32'(ir[DATA_W-1 -: OPC_W]);
    assign dst_sel   = ir[DATA_W-OPC_W-1 -: RSEL_W];
    assign src_sel   = ir[DATA_W-OPC_W-RSEL_W-1 -: RSEL_W];
    // Low bits below the src field carry no meaning.
    assign unused_ir = ^ir;

    always_comb begin
        alu_sel     = AluAdd;
        instr_class = ClsIll;
        case (opc_val)
            OpNop:  instr_class = ClsNop;
            OpAdd:  begin alu_sel = AluAdd; instr_class = ClsAlu; end
            OpSub:  begin alu_sel = AluSub; instr_class = ClsAlu; end
            OpAnd:  begin alu_sel = AluAnd; instr_class = ClsAlu; end
            OpOr:   begin alu_sel = AluOr;  instr_class = ClsAlu; end
            OpXor:  begin alu_sel = AluXor; instr_class = ClsAlu; end
            OpNot:  begin alu_sel = AluNot; instr_class = ClsAlu; end
            OpMov:  begin alu_sel = AluMov; instr_class = ClsAlu; end
            OpLdi:  instr_class = ClsLdi;
            OpLd:   instr_class = ClsLd;
            OpSt:   instr_class = ClsSt;
            OpJmp:  instr_class = ClsJmp;
            OpJz:   instr_class = ClsJz;
            OpJnz:  instr_class = ClsJnz;
            OpRsvd: instr_class = ClsIll;
            OpHlt:  instr_class = ClsHlt;
            default: instr_class = ClsIll;
        endcase
    end

endmodule

// File: rtl/seq_controller.sv
// seq_controller: multi-cycle fetch/decode/execute controller with a req/ack memory handshake.
// Define TRAP_ILLEGAL_EN to trap opcode 0xE into HALT with a sticky illegal flag.
module seq_controller
    import seq_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned OPC_W    = 4,
    parameter int unsigned NUM_REGS = 4,
    localparam int unsigned RSEL_W  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    input  logic              alu_zero,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        alu_sel,
    output logic [RSEL_W-1:0] src_sel,
    output logic [RSEL_W-1:0] dst_sel,
    output logic              reg_we,
    output logic [1:0]        wb_sel,
    output logic [DATA_W-1:0] imm,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              illegal
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [2:0]        alu_sel_q, alu_sel_d;
    logic [RSEL_W-1:0] src_sel_q, src_sel_d;
    logic [RSEL_W-1:0] dst_sel_q, dst_sel_d;
    logic [1:0]        wb_sel_q, wb_sel_d;
    logic              illegal_q, illegal_d;

    logic              req_c;
    logic              we_c;
    logic [2:0]        dec_alu_sel;
    logic [RSEL_W-1:0] dec_src_sel;
    logic [RSEL_W-1:0] dec_dst_sel;
    logic [3:0]        dec_class;
    instr_class_e      cls;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_inc;

    seq_ctrl_decode #(
        .DATA_W (DATA_W),
        .OPC_W  (OPC_W),
        .RSEL_W (RSEL_W)
    ) u_decode (
        .ir          (ir_q),
        .alu_sel     (dec_alu_sel),
        .src_sel     (dec_src_sel),
        .dst_sel     (dec_dst_sel),
        .instr_class (dec_class)
    );

    assign cls    = instr_class_e'(dec_class);
    assign target = mem_rdata[ADDR_W-1:0];
    assign pc_inc = pc_q + ADDR_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StFetch;
            pc_q      <= '0;
            ir_q      <= '0;
            imm_q     <= '0;
            alu_sel_q <= '0;
            src_sel_q <= '0;
            dst_sel_q <= '0;
            wb_sel_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            imm_q     <= imm_d;
            alu_sel_q <= alu_sel_d;
            src_sel_q <= src_sel_d;
            dst_sel_q <= dst_sel_d;
            wb_sel_q  <= wb_sel_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        imm_d     = imm_q;
        alu_sel_d = alu_sel_q;
        src_sel_d = src_sel_q;
        dst_sel_d = dst_sel_q;
        wb_sel_d  = wb_sel_q;
        illegal_d = illegal_q;
        req_c     = 1'b0;
        we_c      = 1'b0;
        reg_we    = 1'b0;
        mem_addr  = pc_q;

        unique case (state_q)
            StFetch: begin
                if (run) begin
                    req_c = 1'b1;
                    if (mem_ack) begin
                        ir_d    = mem_rdata;
                        pc_d    = pc_inc;
                        state_d = StDecode;
                    end
                end
            end
            StDecode: begin
                alu_sel_d = dec_alu_sel;
                src_sel_d = dec_src_sel;
                dst_sel_d = dec_dst_sel;
                wb_sel_d  = wb_sel_for(cls);
                case (cls)
                    ClsHlt: state_d = StHalt;
                    ClsNop: state_d = StFetch;
                    ClsLdi, ClsLd, ClsSt, ClsJmp, ClsJz, ClsJnz: state_d = StOpfetch;
                    ClsIll: begin
`ifdef TRAP_ILLEGAL_EN
                        illegal_d = 1'b1;
                        state_d   = StHalt;
`else
                        state_d   = StFetch;
`endif
                    end
                    default: state_d = StExec;
                endcase
            end
            StExec: begin
                reg_we  = 1'b1;
                state_d = StFetch;
            end
            StOpfetch: begin
                req_c = 1'b1;
                if (mem_ack) begin
                    imm_d = mem_rdata;
                    pc_d  = pc_inc;
                    case (cls)
                        ClsLdi:      state_d = StExec;
                        ClsLd, ClsSt: state_d = StMem;
                        ClsJmp: begin
                            pc_d    = target;
                            state_d = StFetch;
                        end
                        ClsJz: begin
                            if (alu_zero) pc_d = target;
                            state_d = StFetch;
                        end
                        ClsJnz: begin
                            if (!alu_zero) pc_d = target;
                            state_d = StFetch;
                        end
                        default: state_d = StFetch;
                    endcase
                end
            end
            StMem: begin
                req_c    = 1'b1;
                we_c     = (cls == ClsSt);
                mem_addr = imm_q[ADDR_W-1:0];
                if (mem_ack) begin
                    if (cls == ClsLd) begin
                        imm_d   = mem_rdata;
                        state_d = StExec;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            StHalt: state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    // A request raised in FETCH must not leak out while reset is held.
    assign mem_req = req_c & ~reset;
    assign mem_we  = we_c & ~reset;
    assign alu_sel = alu_sel_q;
    assign src_sel = src_sel_q;
    assign dst_sel = dst_sel_q;
    assign wb_sel  = wb_sel_q;
    assign imm     = imm_q;
    assign pc      = pc_q;
    assign halted  = (state_q == StHalt);
    assign illegal = illegal_q;

endmodule

// File: tb/tb_seq_controller.sv
// tb_seq_controller: directed self-checking bench with a behavioural memory and write scoreboards.
module tb_seq_controller;

    logic       clk;
    logic       reset;
    logic       run;
    logic [7:0] mem_rdata;
    logic       mem_ack;
    logic       alu_zero;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [2:0] alu_sel;
    logic [1:0] src_sel;
    logic [1:0] dst_sel;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic [7:0] imm;
    logic [7:0] pc;
    logic       halted;
    logic       illegal;

    typedef struct packed {
        logic [1:0] dst;
        logic [1:0] src;
        logic [2:0] alu;
        logic [1:0] wb;
        logic [7:0] imm;
    } exp_t;

    logic [7:0]  mem [256];
    int unsigned ack_delay;
    int unsigned wait_cnt;
    logic        late_ack;
    int          checks;
    int          errors;
    exp_t        wr_q[$];
    logic [7:0]  st_q[$];
    exp_t        mon_e;
    logic [7:0]  mon_a;
    int          n;

    seq_controller #(
        .DATA_W   (8),
        .ADDR_W   (8),
        .OPC_W    (4),
        .NUM_REGS (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .alu_zero  (alu_zero),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .alu_sel   (alu_sel),
        .src_sel   (src_sel),
        .dst_sel   (dst_sel),
        .reg_we    (reg_we),
        .wb_sel    (wb_sel),
        .imm       (imm),
        .pc        (pc),
        .halted    (halted),
        .illegal   (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    // Memory acks after ack_delay wait cycles; late_ack injects a stray ack.
    assign mem_ack   = (mem_req && (wait_cnt >= ack_delay)) || late_ack;
    assign mem_rdata = mem_ack ? mem[mem_addr] : 8'h00;

    always @(posedge clk) begin
        if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else                     wait_cnt <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Register-write and store scoreboards.
    always @(negedge clk) begin
        if (!reset && reg_we) begin
            chk("reg_we_vs_req", 32'(mem_req), 0);
            chk("reg_we_expected", 32'(wr_q.size() != 0), 1);
            if (wr_q.size() != 0) begin
                mon_e = wr_q.pop_front();
                chk("wr_dst", 32'(dst_sel), 32'(mon_e.dst));
                chk("wr_wb", 32'(wb_sel), 32'(mon_e.wb));
                if (mon_e.wb == 2'd0) begin
                    chk("wr_src", 32'(src_sel), 32'(mon_e.src));
                    chk("wr_alu", 32'(alu_sel), 32'(mon_e.alu));
                end else begin
                    chk("wr_imm", 32'(imm), 32'(mon_e.imm));
                end
            end
        end
        if (!reset && mem_req && mem_we && mem_ack) begin
            chk("st_expected", 32'(st_q.size() != 0), 1);
            if (st_q.size() != 0) begin
                mon_a = st_q.pop_front();
                chk("st_addr", 32'(mem_addr), 32'(mon_a));
            end
        end
    end

    task automatic prep();
        @(negedge clk);
        reset    = 1'b1;
        run      = 1'b0;
        alu_zero = 1'b0;
        late_ack = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic go(input int unsigned delay);
        ack_delay = delay;
        @(negedge clk);
        reset = 1'b0;
        run   = 1'b1;
        #1;
    endtask

    task automatic cycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_we(input int bound, output int cnt);
        cnt = 0;
        while (!reg_we && cnt < bound) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        run       = 1'b0;
        alu_zero  = 1'b0;
        late_ack  = 1'b0;
        ack_delay = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        cycles(2);

        // Reset values, with run already high.
        run = 1'b1;
        #1;
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_reg_we", 32'(reg_we), 0);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_imm", 32'(imm), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_wb_sel", 32'(wb_sel), 0);

        // ADD r1, r2: write-back in cycle 3.
        prep();
        mem[0] = 8'h16;
        wr_q.push_back('{dst: 2'd1, src: 2'd2, alu: 3'd0, wb: 2'd0, imm: 8'h00});
        go(0);
        chk("add_c1_req", 32'(mem_req), 1);
        chk("add_c1_addr", 32'(mem_addr), 0);
        cycles(1);
        chk("add_c2_we", 32'(reg_we), 0);
        chk("add_c2_pc", 32'(pc), 1);
        cycles(1);
        chk("add_c3_we", 32'(reg_we), 1);
        chk("add_c3_dst", 32'(dst_sel), 1);
        chk("add_c3_src", 32'(src_sel), 2);
        chk("add_c3_pc", 32'(pc), 1);
        run = 1'b0;
        cycles(1);
        chk("add_idle_req", 32'(mem_req), 0);

        // LDI r1, 0x5A with a 3-cycle memory wait on each request.
        prep();
        mem[0] = 8'h84;
        mem[1] = 8'h5A;
        wr_q.push_back('{dst: 2'd1, src: 2'd0, alu: 3'd0, wb: 2'd1, imm: 8'h5A});
        go(3);
        for (int i = 0; i < 4; i++) begin
            chk("ldi_hold_req", 32'(mem_req), 1);
            chk("ldi_hold_addr", 32'(mem_addr), 0);
            chk("ldi_hold_pc", 32'(pc), 0);
            cycles(1);
        end
        wait_we(30, n);
        chk("ldi_we_seen", 32'(reg_we), 1);
        chk("ldi_imm", 32'(imm), 32'h5A);
        chk("ldi_pc", 32'(pc), 2);
        run = 1'b0;

        // JZ taken to 0x40, JZ not taken, then JNZ taken to 0x10.
        prep();
        mem[0]    = 8'hC0;
        mem[1]    = 8'h40;
        mem[8'h40] = 8'hC0;
        mem[8'h41] = 8'h60;
        mem[8'h42] = 8'hD0;
        mem[8'h43] = 8'h10;
        alu_zero = 1'b1;
        go(0);
        cycles(3);
        chk("jz_taken_pc", 32'(pc), 32'h40);
        chk("jz_taken_addr", 32'(mem_addr), 32'h40);
        alu_zero = 1'b0;
        cycles(3);
        chk("jz_not_taken_pc", 32'(pc), 32'h42);
        cycles(3);
        chk("jnz_taken_pc", 32'(pc), 32'h10);
        run = 1'b0;

        // ST r1 -> [0x80].
        prep();
        mem[0] = 8'hA1;
        mem[1] = 8'h80;
        st_q.push_back(8'h80);
        go(0);
        cycles(3);
        chk("st_mem_we", 32'(mem_we), 1);
        chk("st_mem_req", 32'(mem_req), 1);
        chk("st_mem_addr", 32'(mem_addr), 32'h80);
        chk("st_src_sel", 32'(src_sel), 1);
        run = 1'b0;
        cycles(1);
        chk("st_after_we", 32'(mem_we), 0);
        chk("st_pc", 32'(pc), 2);

        // LD r1, [0x20]: write-back in cycle 5.
        prep();
        mem[0]    = 8'h94;
        mem[1]    = 8'h20;
        mem[8'h20] = 8'h77;
        wr_q.push_back('{dst: 2'd1, src: 2'd0, alu: 3'd0, wb: 2'd2, imm: 8'h77});
        go(0);
        wait_we(30, n);
        chk("ld_we_seen", 32'(reg_we), 1);
        chk("ld_latency", n + 1, 5);
        chk("ld_imm", 32'(imm), 32'h77);
        run = 1'b0;

        // PC wrap: jump to 0xFF, execute NOP there.
        prep();
        mem[0]    = 8'hB0;
        mem[1]    = 8'hFF;
        mem[8'hFF] = 8'h00;
        go(0);
        cycles(3);
        chk("wrap_pc_ff", 32'(pc), 32'hFF);
        cycles(1);
        chk("wrap_pc_00", 32'(pc), 0);
        run = 1'b0;

        // HLT is absorbing with run held high.
        prep();
        mem[0] = 8'hF0;
        go(0);
        cycles(2);
        chk("hlt_halted", 32'(halted), 1);
        for (int i = 0; i < 4; i++) begin
            cycles(1);
            chk("hlt_no_req", 32'(mem_req), 0);
            chk("hlt_stays", 32'(halted), 1);
        end

        // Reset mid-OPFETCH, then a stray ack with no request.
        prep();
        mem[0] = 8'h84;
        mem[1] = 8'h33;
        go(3);
        cycles(5);
        chk("mid_op_req", 32'(mem_req), 1);
        chk("mid_op_addr", 32'(mem_addr), 1);
        chk("mid_op_dst", 32'(dst_sel), 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_req", 32'(mem_req), 0);
        chk("mid_rst_pc", 32'(pc), 0);
        chk("mid_rst_dst", 32'(dst_sel), 0);
        chk("mid_rst_wb", 32'(wb_sel), 0);
        chk("mid_rst_imm", 32'(imm), 0);
        chk("mid_rst_addr", 32'(mem_addr), 0);
        cycles(1);
        reset    = 1'b0;
        run      = 1'b0;
        late_ack = 1'b1;
        cycles(1);
        late_ack = 1'b0;
        chk("late_ack_pc", 32'(pc), 0);
        chk("late_ack_req", 32'(mem_req), 0);
        chk("late_ack_halt", 32'(halted), 0);

        // Reserved opcode 0xE.
        prep();
        mem[0] = 8'hE0;
        go(0);
        cycles(2);
`ifdef TRAP_ILLEGAL_EN
        chk("ill_flag", 32'(illegal), 1);
        chk("ill_halted", 32'(halted), 1);
        cycles(1);
        chk("ill_no_req", 32'(mem_req), 0);
`else
        chk("ill_pc", 32'(pc), 1);
        chk("ill_addr", 32'(mem_addr), 1);
        chk("ill_flag", 32'(illegal), 0);
        chk("ill_halted", 32'(halted), 0);
`endif
        run = 1'b0;
        cycles(1);

        chk("wr_q_drained", wr_q.size(), 0);
        chk("st_q_drained", st_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
